// File: rtl/trace_pkg.sv
// Shared firmware encodings, condition bit positions and width helpers for trace-chain packers.
package trace_pkg;

   typedef enum logic [1:0] {
      LEN_N    = 2'd0,
      LEN_M    = 2'd1,
      LEN_ONE  = 2'd2,
      LEN_NONE = 2'd3
   } len_mode_e;

   typedef enum logic [1:0] {
      PREC_FULL    = 2'd0,
      PREC_HALF    = 2'd1,
      PREC_QUARTER = 2'd2,
      PREC_NONE    = 2'd3
   } prec_mode_e;

   // Only the low five bits of a mode byte carry meaning, so only those are stored.
   typedef struct packed {
      logic       flush;
      prec_mode_e prec;
      len_mode_e  len;
   } mode_t;

   localparam int COND_EOF0  = 0;
   localparam int COND_NEOF0 = 1;
   localparam int COND_BOF0  = 2;
   localparam int COND_NBOF0 = 3;
   localparam int COND_EOF1  = 4;
   localparam int COND_NEOF1 = 5;
   localparam int COND_BOF1  = 6;
   localparam int COND_NBOF1 = 7;

   function automatic int clog2_min1(input int v);
      return (v <= 1) ? 1 : $clog2(v);
   endfunction

   function automatic int slot_width(input int dw, input int mp);
      return dw / mp;
   endfunction

   function automatic int word_cap(input int n, input int mp);
      return n * mp;
   endfunction

   function automatic int fill_width(input int n, input int mp);
      return $clog2(n * mp) + 1;
   endfunction

endpackage

// File: rtl/packer_slot_shifter.sv
// Combinational: truncates input elements to the selected precision and places k slots
// starting at slot index offset; all other slots are zero.
module packer_slot_shifter
   import trace_pkg::*;
#(
   parameter int N          = 8,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_PREC   = 4
) (
   input  logic [N-1:0][DATA_WIDTH-1:0]                    vec,
   input  prec_mode_e                                      prec,
   input  logic [fill_width(N, MAX_PREC)-1:0]              k,
   input  logic [fill_width(N, MAX_PREC)-1:0]              offset,
   output logic [word_cap(N, MAX_PREC)-1:0][slot_width(DATA_WIDTH, MAX_PREC)-1:0] slots
);

   localparam int SW  = slot_width(DATA_WIDTH, MAX_PREC);
   localparam int CAP = word_cap(N, MAX_PREC);
   localparam int LMP = $clog2(MAX_PREC);

   always_comb begin
      int j, e, c, sh;
      j     = 0;
      e     = 0;
      c     = 0;
      // Each element spans 2**sh slots, most significant chunk first.
      sh    = (int'(prec) > LMP) ? 0 : LMP - int'(prec);
      slots = '0;
      for (int s = 0; s < CAP; s++) begin
         j = s - int'(offset);
         e = j >>> sh;
         c = j & ((1 << sh) - 1);
         if (j >= 0 && j < int'(k) && e < N)
            slots[s] = vec[e][DATA_WIDTH-1-c*SW -: SW];
      end
   end

endmodule

// File: rtl/data_packer_mp.sv
// data_packer_mp: packs per-chain length/precision trace vectors into full N-lane words (DATA_PACKER_STATS_EN adds counters).
// Emitted word registered (latency 1) and held until ready_out; ready_in = !valid_out | ready_out.
module data_packer_mp
   import trace_pkg::*;
#(
   parameter int         N                     = 8,
   parameter int         M                     = 2,
   parameter int         DATA_WIDTH            = 32,
   parameter int         MAX_PREC              = 4,
   parameter int         MAX_CHAINS            = 4,
   parameter logic [7:0] PERSONAL_CONFIG_ID    = 8'd0,
   parameter logic [7:0] INITIAL_FIRMWARE      [0:MAX_CHAINS-1] = '{default: 8'd0},
   parameter logic [7:0] INITIAL_FIRMWARE_COND [0:MAX_CHAINS-1] = '{default: 8'd0}
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    tracing,
   input  logic                                    valid_in,
   output logic                                    ready_in,
   input  logic [1:0]                              eof_in,
   input  logic [1:0]                              bof_in,
   input  logic [clog2_min1(MAX_CHAINS)-1:0]       chainId_in,
   input  logic [7:0]                              configId,
   input  logic [7:0]                              configData,
   input  logic [N-1:0][DATA_WIDTH-1:0]            vector_in,
   output logic [N-1:0][DATA_WIDTH-1:0]            vector_out,
   output logic [fill_width(N, MAX_PREC)-1:0]      fill_out,
   output logic                                    valid_out,
   input  logic                                    ready_out
`ifdef DATA_PACKER_STATS_EN
  ,output logic [31:0]                             words_out_cnt,
   output logic [31:0]                             dropped_cnt
`endif
);

   localparam int SW  = slot_width(DATA_WIDTH, MAX_PREC);
   localparam int CAP = word_cap(N, MAX_PREC);
   localparam int FW  = fill_width(N, MAX_PREC);
   localparam int CW  = clog2_min1(MAX_CHAINS);
   localparam int LMP = $clog2(MAX_PREC);
   localparam logic [7:0] NCH   = 8'(MAX_CHAINS);
   localparam logic [FW:0] CAPW = (FW+1)'(CAP);

   logic [7:0]                   cond_q [MAX_CHAINS];
   mode_t                        mode_q [MAX_CHAINS];
   logic [7:0]                   byte_cnt;
   logic [CW-1:0]                cond_idx, mode_idx;
   logic [CAP-1:0][SW-1:0]       buf_q, shifted, appended, emit_slots;
   logic [N-1:0][DATA_WIDTH-1:0] emit_lanes;
   logic [FW-1:0]                fill_q, k, offset;
   logic [FW:0]                  sum;
   mode_t                        mode_cur;
   logic [7:0]                   cond_cur, flags;
   logic                         commit, cond_ok, accept, hs, ovf, emit;
   int                           lanes;

   assign ready_in = !valid_out || ready_out;
   assign hs       = valid_out && ready_out;

   always_comb begin
      mode_cur = mode_q[chainId_in];
      cond_cur = cond_q[chainId_in];
      flags = '0;
      flags[COND_EOF0]  = eof_in[0];
      flags[COND_NEOF0] = !eof_in[0];
      flags[COND_BOF0]  = bof_in[0];
      flags[COND_NBOF0] = !bof_in[0];
      flags[COND_EOF1]  = eof_in[1];
      flags[COND_NEOF1] = !eof_in[1];
      flags[COND_BOF1]  = bof_in[1];
      flags[COND_NBOF1] = !bof_in[1];
      cond_ok = (cond_cur == 8'd0) || ((cond_cur & flags) != 8'd0);
      case (mode_cur.len)
         LEN_N:   lanes = N;
         LEN_M:   lanes = M;
         LEN_ONE: lanes = 1;
         default: lanes = 0;
      endcase
      commit = (mode_cur.len != LEN_NONE) && (mode_cur.prec != PREC_NONE) &&
               (int'(mode_cur.prec) <= LMP);
      k      = commit ? FW'(lanes * (MAX_PREC >> mode_cur.prec)) : '0;
      accept = valid_in && ready_in && tracing && commit && cond_ok;
      sum    = {1'b0, fill_q} + {1'b0, k};
      ovf    = sum > CAPW;
      // On overflow the incoming slots start a fresh word instead of appending.
      offset = ovf ? '0 : fill_q;
      emit   = accept && (ovf || sum == CAPW || (mode_cur.flush && eof_in[0]));
   end

   packer_slot_shifter #(
      .N          (N),
      .DATA_WIDTH (DATA_WIDTH),
      .MAX_PREC   (MAX_PREC)
   ) u_shift (
      .vec    (vector_in),
      .prec   (mode_cur.prec),
      .k      (k),
      .offset (offset),
      .slots  (shifted)
   );

   always_comb begin
      appended   = buf_q | shifted;
      emit_slots = ovf ? buf_q : appended;
      emit_lanes = '0;
      for (int i = 0; i < N; i++)
         for (int c = 0; c < MAX_PREC; c++)
            emit_lanes[i][(MAX_PREC-1-c)*SW +: SW] = emit_slots[i*MAX_PREC+c];
      cond_idx = byte_cnt[CW-1:0];
      mode_idx = CW'(byte_cnt - NCH);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_out  <= 1'b0;
         vector_out <= '0;
         fill_out   <= '0;
         buf_q      <= '0;
         fill_q     <= '0;
         byte_cnt   <= '0;
         for (int i = 0; i < MAX_CHAINS; i++) begin
            cond_q[i] <= INITIAL_FIRMWARE_COND[i];
            mode_q[i] <= mode_t'(INITIAL_FIRMWARE[i][4:0]);
         end
      end else begin
         if (hs)
            valid_out <= 1'b0;
         if (accept) begin
            if (emit) begin
               valid_out  <= 1'b1;
               vector_out <= emit_lanes;
               fill_out   <= ovf ? fill_q : sum[FW-1:0];
            end
            if (ovf) begin
               buf_q  <= shifted;
               fill_q <= k;
            end else if (emit) begin
               buf_q  <= '0;
               fill_q <= '0;
            end else begin
               buf_q  <= appended;
               fill_q <= sum[FW-1:0];
            end
         end
         if (!tracing) begin
            if (configId == PERSONAL_CONFIG_ID) begin
               if (byte_cnt < NCH)
                  cond_q[cond_idx] <= configData;
               else if (byte_cnt < 8'(2*MAX_CHAINS))
                  mode_q[mode_idx] <= mode_t'(configData[4:0]);
               // Saturate so trailing bytes never wrap back onto the firmware.
               if (byte_cnt < 8'(2*MAX_CHAINS))
                  byte_cnt <= byte_cnt + 8'd1;
            end else begin
               byte_cnt <= '0;
            end
         end
      end
   end

`ifdef DATA_PACKER_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         words_out_cnt <= '0;
         dropped_cnt   <= '0;
      end else begin
         if (hs)
            words_out_cnt <= words_out_cnt + 32'd1;
         if (valid_in && (!ready_in || (tracing && !commit)))
            dropped_cnt <= dropped_cnt + 32'd1;
      end
   end
`endif

endmodule
